// File: rtl/ncl_dr_pipeline.sv
// Clocked dual-rail NCL pipeline model: DEPTH stages of WIDTH-bit TH22 rail
// registers, each with completion detection feeding the upstream enable.
// One clock edge stands for one gate delay.
module ncl_dr_pipeline #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             init,
   input  logic [WIDTH-1:0] in_t,
   input  logic [WIDTH-1:0] in_f,
   output logic             in_ack,
   output logic [WIDTH-1:0] out_t,
   output logic [WIDTH-1:0] out_f,
   input  logic             out_ack,
   output logic             illegal,
   output logic [CNT_W-1:0] data_count
);

   localparam int unsigned STG_W = DEPTH * WIDTH;

   logic [DEPTH-1:0][WIDTH-1:0] t_q, t_d, f_q, f_d;
   logic [DEPTH-1:0][WIDTH-1:0] src_t_c, src_f_c;
   logic [DEPTH-1:0]            ack_q, ack_d, en_c;
   logic [WIDTH-1:0]            bad_c, in_t_m_c, in_f_m_c;
   logic                        illegal_q, illegal_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;

   // Mask bits with both input rails high so they look like NULL at stage 0.
   always_comb begin
      bad_c    = in_t & in_f;
      in_t_m_c = in_t & ~bad_c;
      in_f_m_c = in_f & ~bad_c;
   end

   // Stage k sources from stage k-1 (stage 0 from the masked inputs); its
   // enable is the inverted completion of the stage after it.
   always_comb begin
      src_t_c = STG_W'({t_q, in_t_m_c});
      src_f_c = STG_W'({f_q, in_f_m_c});
      en_c    = ~DEPTH'({out_ack, ack_q} >> 1);
   end

   // TH22 rail update with hysteresis and per-stage completion detection.
   always_comb begin
      t_d   = t_q;
      f_d   = f_q;
      ack_d = ack_q;
      for (int k = 0; k < DEPTH; k++) begin
         // en=1: rails can only rise; en=0: rails can only fall.
         if (en_c[k]) begin
            t_d[k] = t_q[k] | src_t_c[k];
            f_d[k] = f_q[k] | src_f_c[k];
         end else begin
            t_d[k] = t_q[k] & src_t_c[k];
            f_d[k] = f_q[k] & src_f_c[k];
         end
         // Completion reads the registered rails, so it lags them one edge.
         if (&(t_q[k] ^ f_q[k])) begin
            ack_d[k] = 1'b1;
         end else if (~|(t_q[k] | f_q[k])) begin
            ack_d[k] = 1'b0;
         end
      end
   end

   // Sticky illegal flag and delivered-DATA counter on last-stage ack rise.
   always_comb begin
      illegal_d = illegal_q | (|bad_c);
      cnt_d     = cnt_q;
      if (ack_d[DEPTH-1] && !ack_q[DEPTH-1]) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State registers; init discards everything in flight.
   always_ff @(posedge clk) begin
      if (init) begin
         t_q       <= '0;
         f_q       <= '0;
         ack_q     <= '0;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         t_q       <= t_d;
         f_q       <= f_d;
         ack_q     <= ack_d;
         illegal_q <= illegal_d;
         cnt_q     <= cnt_d;
      end
   end

   assign in_ack     = ack_q[0];
   assign out_t      = t_q[DEPTH-1];
   assign out_f      = f_q[DEPTH-1];
   assign illegal    = illegal_q;
   assign data_count = cnt_q;

endmodule

// File: tb/tb_ncl_dr_pipeline.sv
// Scoreboard bench for ncl_dr_pipeline: producer pushes expected wavefronts,
// an independent monitor pops them as complete DATA appears at the output.
module tb_ncl_dr_pipeline;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned TMO   = 500;

   logic             clk = 1'b0;
   logic             init = 1'b1;
   logic [WIDTH-1:0] in_t = '0, in_f = '0;
   logic             out_ack = 1'b0;
   logic             in_ack, illegal, in_ack_w, illegal_w;
   logic [WIDTH-1:0] out_t, out_f, out_t_w, out_f_w;
   logic [15:0]      data_count;
   logic [3:0]       data_count_w;

   int checks   = 0;
   int failures = 0;
   int mode     = 0;   // 0: out_ack=0, 1: consumer follows outputs, 2: out_ack=1
   byte unsigned exp_q[$];

   always #5 clk = ~clk;

   ncl_dr_pipeline #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(16)) dut (
      .clk(clk), .init(init), .in_t(in_t), .in_f(in_f), .in_ack(in_ack),
      .out_t(out_t), .out_f(out_f), .out_ack(out_ack), .illegal(illegal),
      .data_count(data_count)
   );

   ncl_dr_pipeline #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(4)) dut_w (
      .clk(clk), .init(init), .in_t(in_t), .in_f(in_f), .in_ack(in_ack_w),
      .out_t(out_t_w), .out_f(out_f_w), .out_ack(out_ack), .illegal(illegal_w),
      .data_count(data_count_w)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one DATA wavefront under the four-phase rule, then return to NULL.
   task automatic send(input byte unsigned v);
      int n;
      n = 0;
      while (in_ack !== 1'b0 && n < TMO) begin step(); n++; end
      chk("send_req_wait", 32'(in_ack), 32'd0);
      in_t = v;
      in_f = ~v;
      exp_q.push_back(v);
      n = 0;
      while (in_ack !== 1'b1 && n < TMO) begin step(); n++; end
      chk("send_ack_wait", 32'(in_ack), 32'd1);
      in_t = '0;
      in_f = '0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < TMO) begin step(); n++; end
      chk("drain_queue", 32'(exp_q.size()), 32'd0);
      repeat (6) step();
   endtask

   task automatic do_init(input int edges);
      in_t = '0;
      in_f = '0;
      init = 1'b1;
      repeat (edges) step();
      init = 1'b0;
      step();
   endtask

   // Monitor and consumer: compare each new complete output DATA wavefront.
   initial begin : monitor
      logic prev, cur;
      byte unsigned e;
      logic [7:0] ne;
      prev = 1'b0;
      forever begin
         step();
         cur = &(out_t ^ out_f);
         if (cur && !prev) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_data: got t=0x%0h f=0x%0h expected none", out_t, out_f);
            end else begin
               e  = exp_q.pop_front();
               ne = ~e;
               chk("out_data", {16'h0, out_t, out_f}, {16'h0, e, ne});
            end
         end
         prev = cur;
         case (mode)
            0: out_ack = 1'b0;
            2: out_ack = 1'b1;
            default: begin
               if (cur) out_ack = 1'b1;
               else if (~|(out_t | out_f)) out_ack = 1'b0;
            end
         endcase
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      // Reset with garbage (including both-rails-high) on the inputs.
      step();
      init = 1'b1;
      in_t = 8'hFF;
      in_f = 8'h33;
      step();
      step();
      chk("rst_out_t", 32'(out_t), 32'h0);
      chk("rst_out_f", 32'(out_f), 32'h0);
      chk("rst_in_ack", 32'(in_ack), 32'h0);
      chk("rst_illegal", 32'(illegal), 32'h0);
      chk("rst_count", 32'(data_count), 32'h0);
      do_init(1);

      // Single wavefront latency with out_ack held 0.
      exp_q.push_back(8'hA5);
      in_t = 8'hA5;
      in_f = 8'h5A;
      step(); chk("single_in_ack_e1", 32'(in_ack), 32'd0);
      step(); chk("single_in_ack_e2", 32'(in_ack), 32'd1);
      step(); chk("single_out_e3", 32'(out_t), 32'h0);
      step(); chk("single_out_t_e4", 32'(out_t), 32'hA5);
              chk("single_out_f_e4", 32'(out_f), 32'h5A);
              chk("single_cnt_e4", 32'(data_count), 32'd0);
      step(); chk("single_cnt_e5", 32'(data_count), 32'd1);
      do_init(2);

      // Free-running transfer of 0x00..0xFF.
      mode = 1;
      for (int i = 0; i < 256; i++) send(8'(i));
      drain();
      chk("free_count", 32'(data_count), 32'd256);

      // Partial wavefront: bit 7 arrives 10 edges late.
      exp_q.push_back(8'h3C);
      in_t = 8'h3C;
      in_f = 8'h43;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("partial_in_ack_hold", 32'(in_ack), 32'd0);
      end
      in_f = 8'hC3;
      step(); chk("partial_in_ack_p1", 32'(in_ack), 32'd0);
      step(); chk("partial_in_ack_p2", 32'(in_ack), 32'd1);
      in_t = '0;
      in_f = '0;
      drain();

      // Backpressure: out_ack held 1 while 6 wavefronts are offered.
      mode = 2;
      step();
      step();
      fork
         begin
            for (int i = 0; i < 6; i++) send(8'(8'h60 + i));
         end
         begin
            repeat (15) step();
            for (int i = 0; i < 20; i++) begin
               step();
               chk("bp_in_ack", 32'(in_ack), 32'd1);
               chk("bp_out_t", 32'(out_t), 32'd0);
               chk("bp_out_f", 32'(out_f), 32'd0);
            end
            mode = 1;
         end
      join
      drain();

      // Illegal input on bit 3, then init mid-flight.
      chk("pre_illegal", 32'(illegal), 32'd0);
      in_t = 8'h0F;
      in_f = 8'hF8;
      step(); chk("illegal_set", 32'(illegal), 32'd1);
      repeat (9) step();
      chk("illegal_stall_in_ack", 32'(in_ack), 32'd0);
      chk("illegal_sticky", 32'(illegal), 32'd1);
      in_t = '0;
      in_f = '0;
      init = 1'b1;
      step();
      chk("init_out_t", 32'(out_t), 32'd0);
      chk("init_out_f", 32'(out_f), 32'd0);
      chk("init_in_ack", 32'(in_ack), 32'd0);
      chk("init_illegal", 32'(illegal), 32'd0);
      chk("init_count", 32'(data_count), 32'd0);
      init = 1'b0;
      step();

      // Counter wrap on the 4-bit instance.
      for (int i = 0; i < 17; i++) send(8'(8'h10 + i));
      drain();
      chk("wrap_count_w", 32'(data_count_w), 32'd1);
      chk("wrap_count", 32'(data_count), 32'd17);
      chk("wrap_illegal_w", 32'(illegal_w), 32'd0);

      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
